// File: rtl/rls_ser_pkg.sv
// rls_ser_pkg: shared state encoding, sync byte and word geometry for the result serializer
package rls_ser_pkg;
    typedef enum logic [1:0] {S_IDLE, S_HDR, S_SEND} state_t;
    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    function automatic int bytes_per_word(input int n);
        return n / 8;
    endfunction
endpackage

// File: rtl/rls_result_serializer_if.sv
// rls_result_serializer_if: sample strobe in, byte stream out with valid/ready
interface rls_result_serializer_if #(parameter int nBits = 32);
    logic             write;
    logic [nBits-1:0] x;
    logic [7:0]       out_data;
    logic             out_valid;
    logic             out_ready;
    modport master (output write, x, out_ready, input out_data, out_valid);
    modport slave  (input write, x, out_ready, output out_data, out_valid);
endinterface

// File: rtl/rls_sync_fifo.sv
// rls_sync_fifo: single-clock FIFO; pop_data always shows the current head word
module rls_sync_fifo #(
    parameter int nBits = 32,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [nBits-1:0]           push_data,
    input  logic                       pop,
    output logic [nBits-1:0]           pop_data,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       full,
    output logic                       empty
);
    localparam int AW = $clog2(DEPTH);
    logic [nBits-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr, r_rd;
    logic [AW:0]      r_level;
    logic             w_push, w_pop;
    assign full     = r_level == (AW+1)'(DEPTH);
    assign empty    = r_level == '0;
    assign w_push   = push & ~full;
    assign w_pop    = pop & ~empty;
    assign pop_data = r_mem[r_rd];
    assign level    = r_level;
    always_ff @(posedge clk)
        if (w_push) r_mem[r_wr] <= push_data;
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_level <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + 1'b1;
            if (w_pop) r_rd <= r_rd + 1'b1;
            r_level <= r_level + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
        end
    end
endmodule

// File: rtl/rls_result_serializer.sv
// rls_result_serializer: buffers sample words and streams them MSB-first as bytes.
// Define RLS_FRAME_HDR_EN to prefix every word with SYNC_BYTE.
module rls_result_serializer
    import rls_ser_pkg::*;
#(
    parameter int nBits = 32,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     reset,
    rls_result_serializer_if.slave   bus,
    output logic [AW:0]              level,
    output logic                     overflow
);
    localparam int NB = bytes_per_word(nBits);
    localparam int IW = NB > 1 ? $clog2(NB) : 1;
`ifdef RLS_FRAME_HDR_EN
    localparam state_t S_LOAD = S_HDR;
`else
    localparam state_t S_LOAD = S_SEND;
`endif
    state_t           r_state;
    logic [nBits-1:0] r_sh;
    logic [IW-1:0]    r_idx;
    logic             r_valid, r_ovf;
    logic [nBits-1:0] w_head;
    logic             w_full, w_empty, w_hs, w_last, w_pop;
    rls_sync_fifo #(.nBits(nBits), .DEPTH(DEPTH)) u_fifo (
        .clk(clk), .reset(reset), .push(bus.write), .push_data(bus.x), .pop(w_pop),
        .pop_data(w_head), .level(level), .full(w_full), .empty(w_empty)
    );
    assign w_hs   = r_valid & bus.out_ready;
    assign w_last = r_idx == IW'(NB - 1);
    // a pop both starts a word from IDLE and chains the next word on the final byte
    assign w_pop  = ~w_empty & (r_state == S_IDLE | (r_state == S_SEND & w_hs & w_last));
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_sh    <= '0;
            r_idx   <= '0;
            r_valid <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            if (bus.write & w_full) r_ovf <= 1'b1;
            if (w_pop) begin
                r_sh    <= w_head;
                r_idx   <= '0;
                r_state <= S_LOAD;
                r_valid <= 1'b1;
            end else if (r_state == S_HDR && w_hs) begin
                r_state <= S_SEND;
            end else if (r_state == S_SEND && w_hs) begin
                if (!w_last) begin
                    r_sh  <= r_sh << 8;
                    r_idx <= r_idx + 1'b1;
                end else begin
                    r_state <= S_IDLE;
                    r_valid <= 1'b0;
                end
            end
        end
    end
    assign bus.out_data  = r_state == S_HDR ? SYNC_BYTE : r_sh[nBits-1 -: 8];
    assign bus.out_valid = r_valid;
    assign overflow      = r_ovf;
endmodule

// File: tb/tb_rls_result_serializer.sv
// tb_rls_result_serializer: table-driven cycle vectors plus overflow and mid-word reset sequences
module tb_rls_result_serializer;
    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] level;
    logic       overflow;
    int         errors = 0;
    int         checks = 0;
    rls_result_serializer_if #(.nBits(32)) bus ();
    rls_result_serializer #(.nBits(32), .DEPTH(16)) dut (
        .clk(clk), .reset(reset), .bus(bus), .level(level), .overflow(overflow)
    );
    always #5 clk = ~clk;
    typedef struct {
        logic        rst, wr, rdy;
        logic [31:0] x;
        logic        ev;
        logic [7:0]  ed;
        logic [4:0]  el;
        logic        eo;
    } vec_t;
    vec_t tbl[$];
    task automatic v(logic rst, logic wr, logic [31:0] x, logic rdy, logic ev, logic [7:0] ed, logic [4:0] el, logic eo);
        vec_t t;
        t.rst = rst; t.wr = wr; t.x = x; t.rdy = rdy; t.ev = ev; t.ed = ed; t.el = el; t.eo = eo;
        tbl.push_back(t);
    endtask
    task automatic chk(string n, logic [31:0] a, logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, a, e);
        end
    endtask
    task automatic step(logic r, logic w, logic [31:0] xx, logic rd);
        reset = r; bus.write = w; bus.x = xx; bus.out_ready = rd;
        @(posedge clk);
        #1;
    endtask
    initial begin
        logic [31:0] got[$];
        logic [31:0] w;
        int nb;
        reset = 1'b1; bus.write = 1'b0; bus.x = '0; bus.out_ready = 1'b0;
`ifndef RLS_FRAME_HDR_EN
        v(1,0,0,1, 0,8'h00,0,0); v(1,0,0,1, 0,8'h00,0,0);
        v(0,1,32'h00018000,1, 0,0,1,0);
        v(0,0,0,1, 1,8'h00,0,0); v(0,0,0,1, 1,8'h01,0,0); v(0,0,0,1, 1,8'h80,0,0);
        v(0,0,0,1, 1,8'h00,0,0); v(0,0,0,1, 0,0,0,0);
        v(0,1,32'hFFFF8000,0, 0,0,1,0);
        v(0,0,0,0, 1,8'hFF,0,0); v(0,0,0,0, 1,8'hFF,0,0); v(0,0,0,1, 1,8'hFF,0,0);
        v(0,0,0,0, 1,8'hFF,0,0); v(0,0,0,1, 1,8'h80,0,0); v(0,0,0,0, 1,8'h80,0,0);
        v(0,0,0,1, 1,8'h00,0,0); v(0,0,0,0, 1,8'h00,0,0); v(0,0,0,1, 0,0,0,0);
        v(0,1,32'h11223344,1, 0,0,1,0); v(0,1,32'h55667788,1, 1,8'h11,1,0);
        v(0,1,32'h99AABBCC,1, 1,8'h22,2,0); v(0,0,0,1, 1,8'h33,2,0); v(0,0,0,1, 1,8'h44,2,0);
        v(0,0,0,1, 1,8'h55,1,0); v(0,0,0,1, 1,8'h66,1,0); v(0,0,0,1, 1,8'h77,1,0);
        v(0,0,0,1, 1,8'h88,1,0); v(0,0,0,1, 1,8'h99,0,0); v(0,0,0,1, 1,8'hAA,0,0);
        v(0,0,0,1, 1,8'hBB,0,0); v(0,0,0,1, 1,8'hCC,0,0); v(0,0,0,1, 0,0,0,0);
        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].rst, tbl[i].wr, tbl[i].x, tbl[i].rdy);
            chk($sformatf("row%0d valid", i), {31'd0, bus.out_valid}, {31'd0, tbl[i].ev});
            if (tbl[i].ev || tbl[i].rst) chk($sformatf("row%0d data", i), {24'd0, bus.out_data}, {24'd0, tbl[i].ed});
            chk($sformatf("row%0d level", i), {27'd0, level}, {27'd0, tbl[i].el});
            chk($sformatf("row%0d ovf", i), {31'd0, overflow}, {31'd0, tbl[i].eo});
        end
        for (int i = 0; i < 18; i++) begin
            step(0, 1, i, 0);
            if (i == 16) begin
                chk("fill level", {27'd0, level}, 32'd16);
                chk("fill ovf", {31'd0, overflow}, 32'd0);
            end
        end
        chk("full level", {27'd0, level}, 32'd16);
        chk("full ovf", {31'd0, overflow}, 32'd1);
        chk("full valid", {31'd0, bus.out_valid}, 32'd1);
        nb = 0; w = '0;
        for (int c = 0; c < 100; c++) begin
            if (bus.out_valid) begin
                w = {w[23:0], bus.out_data};
                nb++;
                if (nb % 4 == 0) got.push_back(w);
            end
            step(0, c == 3, 32'h99, 1);
            if (c == 3) chk("full write with pop dropped", {27'd0, level}, 32'd15);
        end
        chk("drain bytes", nb, 68);
        for (int k = 0; k < 17; k++)
            chk($sformatf("drain word%0d", k), k < got.size() ? got[k] : 32'hXXXXXXXX, k);
        chk("drain ovf sticky", {31'd0, overflow}, 32'd1);
        chk("drain level", {27'd0, level}, 32'd0);
        step(0, 1, 32'hDEADBEEF, 1);
        step(0, 0, 0, 1);
        chk("rst mw byte0", {24'd0, bus.out_data}, 32'hDE);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        chk("rst mw byte2", {24'd0, bus.out_data}, 32'hBE);
        step(1, 0, 0, 1);
        chk("rst mw valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst mw level", {27'd0, level}, 32'd0);
        chk("rst mw ovf", {31'd0, overflow}, 32'd0);
        chk("rst mw data", {24'd0, bus.out_data}, 32'd0);
        step(0, 1, 32'h00000001, 1);
        nb = 0; w = '0;
        for (int c = 0; c < 10; c++) begin
            if (bus.out_valid) begin
                w = {w[23:0], bus.out_data};
                nb++;
            end
            step(0, 0, 0, 1);
        end
        chk("post rst bytes", nb, 4);
        chk("post rst word", w, 32'h00000001);
`else
        step(1, 0, 0, 1);
        step(1, 0, 0, 1);
        chk("hdr rst valid", {31'd0, bus.out_valid}, 32'd0);
        chk("hdr rst data", {24'd0, bus.out_data}, 32'd0);
        step(0, 1, 32'h00018000, 1);
        chk("hdr level", {27'd0, level}, 32'd1);
        chk("hdr valid lat", {31'd0, bus.out_valid}, 32'd0);
        step(0, 0, 0, 0);
        chk("hdr sync", {24'd0, bus.out_data}, 32'hA5);
        step(0, 0, 0, 0);
        chk("hdr sync held", {24'd0, bus.out_data}, 32'hA5);
        step(0, 0, 0, 1);
        chk("hdr b0", {24'd0, bus.out_data}, 32'h00);
        step(0, 0, 0, 1);
        chk("hdr b1", {24'd0, bus.out_data}, 32'h01);
        step(0, 0, 0, 1);
        chk("hdr b2", {24'd0, bus.out_data}, 32'h80);
        step(0, 0, 0, 1);
        chk("hdr b3", {24'd0, bus.out_data}, 32'h00);
        chk("hdr b3 valid", {31'd0, bus.out_valid}, 32'd1);
        step(0, 0, 0, 1);
        chk("hdr end valid", {31'd0, bus.out_valid}, 32'd0);
        chk("hdr end level", {27'd0, level}, 32'd0);
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
